inst_fetch_unit: RTL and testbench
==================================

Name: inst_fetch_unit

Overview:
- Front end of the RISC-V core; the producer side of the decoder's inst/pc_sel interface.
- Owns the PC and issues requests to instruction memory over a req/gnt/rvalid protocol.
- Buffers returned instructions, with their PC, in a small FIFO and presents them to decode with valid/ready.
- Applies pc_sel redirects from the branch path, flushing buffered and in-flight instructions.

Parameters:
- PC_WIDTH, 32, PC and address width.
- INST_WIDTH, 32, instruction width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 2, fetch buffer entries and also the maximum outstanding requests; power of 2, at least 2.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous reset, active low.
- imem_req  out  1  fetch request valid.
- imem_addr  out  PC_WIDTH  fetch address, word aligned.
- imem_gnt  in  1  request accepted this cycle; a transfer is imem_req && imem_gnt.
- imem_rvalid  in  1  response valid; responses return in order, at least 1 cycle after gnt.
- imem_rdata  in  INST_WIDTH  response instruction.
- inst_valid  out  1  FIFO head valid.
- inst  out  INST_WIDTH  FIFO head instruction.
- inst_pc  out  PC_WIDTH  PC of the FIFO head.
- inst_ready  in  1  decode consumes the head this cycle.
- pc_sel  in  1  redirect strobe, 1 cycle.
- br_target  in  PC_WIDTH  redirect address, sampled when pc_sel=1.

Behaviour:
- Reset values:
  - fetch_pc=RESET_PC; FIFO empty; outstanding=0; drop_cnt=0; state=BOOT.
  - imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0.
- States:
  - BOOT: imem_req=0 for exactly 1 cycle after reset release, then RUN.
  - RUN: imem_req=1 when outstanding + fifo_count < FIFO_DEPTH (credit rule, so the FIFO can never overflow); imem_addr=fetch_pc. On a transfer, fetch_pc += 4 (wraps modulo 2^PC_WIDTH) and outstanding++.
  - FLUSH: imem_req=0; each imem_rvalid is discarded and decrements drop_cnt; when drop_cnt=0, go to RUN. Entered from RUN only when a redirect leaves outstanding>0.
- Responses in RUN: imem_rvalid pushes {fetch address, imem_rdata} into the FIFO and decrements outstanding. The PC is tracked by a parallel request-address queue of depth FIFO_DEPTH.
- FIFO timing:
  - Push and pop in the same cycle are both allowed; count is unchanged.
  - A response arriving into an empty FIFO is visible on inst_valid the next cycle (1-cycle rvalid-to-valid latency).
- Redirect (pc_sel=1), highest priority:
  - In the same cycle: imem_req is forced 0; FIFO cleared at the edge; inst_valid=0 from the next cycle; any inst_ready that cycle is ignored.
  - fetch_pc <= {br_target[PC_WIDTH-1:2],2'b00}.
  - drop_cnt <= outstanding + (imem_rvalid ? -1 : 0), counting responses still owed; outstanding <= 0.
  - Go to FLUSH if that drop_cnt>0, else RUN.
  - A redirect during FLUSH reloads fetch_pc and keeps counting down drop_cnt.
- imem_gnt while imem_req=0 is ignored.
- imem_rvalid with outstanding=0 and drop_cnt=0 is a protocol error: discard it.
- Asynchronous reset mid-operation returns every register to its reset value immediately.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined:
  - Adds output fetch_misalign (1 bit, reset 0).
  - A redirect with br_target[1:0]!=0 sets fetch_misalign=1 and parks the unit in a HALT state: imem_req=0, FIFO empty, in-flight responses still dropped.
  - Only a later aligned redirect clears the flag and resumes fetching.
- Undefined: no port and no HALT state; br_target[1:0] is silently forced to 00.

Test Plan:
- Reset, then gnt=1 every cycle, rvalid 1 cycle after gnt, inst_ready=1 -> requests to 0x0,0x4,0x8 on consecutive cycles after BOOT; inst_pc follows 0x0,0x4,0x8 in order.
- inst_ready=0, gnt=1 -> exactly 2 transfers (0x0, 0x4); imem_req stays 0 while the FIFO holds 2; after one pop, the next request goes to 0x8.
- Two requests outstanding, pc_sel=1 with br_target=0x100 -> both later rvalids discarded (FLUSH), next request address 0x100, first inst_pc=0x100.
- pc_sel=1, br_target=0x40, outstanding=0 -> next cycle imem_req=1 to 0x40 with no FLUSH cycle; any buffered FIFO entry is gone.
- fetch_pc=0xFFFF_FFFC, transfer -> next request address 0x0000_0000 (wrap).
- With FETCH_MISALIGN_TRAP_EN: pc_sel, br_target=0x102 -> fetch_misalign=1, no requests; then pc_sel, br_target=0x200 -> flag clears, fetch resumes at 0x200.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: owns the PC, drives imem req/gnt/rvalid, buffers {pc,inst} for decode.
// Optional macro FETCH_MISALIGN_TRAP_EN: misaligned redirect target raises fetch_misalign and parks in HALT.
module inst_fetch_unit #(
  parameter int                     PC_WIDTH   = 32,
  parameter int                     INST_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]    RESET_PC   = '0,
  parameter int                     FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic                  imem_req,
  output logic [PC_WIDTH-1:0]   imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [INST_WIDTH-1:0] imem_rdata,
  output logic                  inst_valid,
  output logic [INST_WIDTH-1:0] inst,
  output logic [PC_WIDTH-1:0]   inst_pc,
  input  logic                  inst_ready,
  input  logic                  pc_sel,
  input  logic [PC_WIDTH-1:0]   br_target
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic                  fetch_misalign
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {S_BOOT, S_RUN, S_FLUSH, S_HALT} state_e;
`else
  typedef enum logic [1:0] {S_BOOT, S_RUN, S_FLUSH} state_e;
`endif

  state_e                state_q, state_d;
  logic [PC_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0]      outst_q, outst_d, drop_q, drop_d, cnt_q, cnt_d;
  logic [PTR_W-1:0]      wr_q, wr_d, rd_q, rd_d, aq_wr_q, aq_wr_d, aq_rd_q, aq_rd_d;
  logic [INST_WIDTH-1:0] inst_mem [FIFO_DEPTH];
  logic [PC_WIDTH-1:0]   pc_mem   [FIFO_DEPTH];
  logic [PC_WIDTH-1:0]   aq_mem   [FIFO_DEPTH];

  logic                  credit, xfer, rsp_take, rsp_drop, pop;
  logic [CNT_W-1:0]      owed;
  logic [PC_WIDTH-1:0]   redir_pc;

  // Credit counts in-flight requests plus buffered entries so a response always has a slot.
  assign credit    = ({1'b0, outst_q} + {1'b0, cnt_q}) < DEPTH_C;
  assign imem_req  = (state_q == S_RUN) && credit && !pc_sel;
  assign xfer      = imem_req && imem_gnt;
  assign rsp_take  = imem_rvalid && (state_q == S_RUN) && (outst_q != '0) && !pc_sel;
  assign rsp_drop  = imem_rvalid && (drop_q != '0);
  assign inst_valid = (cnt_q != '0);
  assign pop       = inst_valid && inst_ready && !pc_sel;
  assign owed      = outst_q + drop_q;
  assign redir_pc  = br_target & ~(PC_WIDTH'(3));
  assign imem_addr = fetch_pc_q;
  assign inst      = inst_valid ? inst_mem[rd_q] : '0;
  assign inst_pc   = inst_valid ? pc_mem[rd_q]   : '0;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;
  assign fetch_misalign = misalign_q;
`endif

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    cnt_d      = cnt_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    aq_wr_d    = aq_wr_q;
    aq_rd_d    = aq_rd_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    misalign_d = misalign_q;
`endif
    if (pc_sel) begin
      // Redirect wins: everything buffered or in flight becomes stale.
      fetch_pc_d = redir_pc;
      drop_d     = owed - CNT_W'(imem_rvalid && (owed != '0));
      outst_d    = '0;
      cnt_d      = '0;
      wr_d       = '0;
      rd_d       = '0;
      aq_wr_d    = '0;
      aq_rd_d    = '0;
      state_d    = (drop_d != '0) ? S_FLUSH : S_RUN;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_d = |br_target[1:0];
      if (|br_target[1:0]) state_d = S_HALT;
`endif
    end else begin
      if (xfer) begin
        fetch_pc_d = fetch_pc_q + PC_WIDTH'(4);
        aq_wr_d    = aq_wr_q + PTR_W'(1);
      end
      if (rsp_take) begin
        wr_d    = wr_q + PTR_W'(1);
        aq_rd_d = aq_rd_q + PTR_W'(1);
      end
      if (pop) rd_d = rd_q + PTR_W'(1);
      outst_d = outst_q + CNT_W'(xfer) - CNT_W'(rsp_take);
      cnt_d   = cnt_q + CNT_W'(rsp_take) - CNT_W'(pop);
      if (rsp_drop) drop_d = drop_q - CNT_W'(1);
      case (state_q)
        S_BOOT:  state_d = S_RUN;
        S_FLUSH: if (drop_d == '0) state_d = S_RUN;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_BOOT;
      fetch_pc_q <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
      cnt_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      aq_wr_q    <= '0;
      aq_rd_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      aq_wr_q    <= aq_wr_d;
      aq_rd_q    <= aq_rd_d;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) misalign_q <= 1'b0;
    else          misalign_q <= misalign_d;
  end
`endif

  // Payload storage; validity is tracked entirely by the pointers and counts above.
  always_ff @(posedge clk) begin
    if (xfer) aq_mem[aq_wr_q] <= fetch_pc_q;
    if (rsp_take) begin
      inst_mem[wr_q] <= imem_rdata;
      pc_mem[wr_q]   <= aq_mem[aq_rd_q];
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: in-order memory responder plus per-scenario checks.
module tb_inst_fetch_unit;
  localparam int PW = 32;
  localparam int IW = 32;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          imem_req;
  logic [PW-1:0] imem_addr;
  logic          imem_gnt = 1'b0;
  logic          imem_rvalid;
  logic [IW-1:0] imem_rdata;
  logic          inst_valid;
  logic [IW-1:0] inst;
  logic [PW-1:0] inst_pc;
  logic          inst_ready = 1'b0;
  logic          pc_sel = 1'b0;
  logic [PW-1:0] br_target = '0;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic          fetch_misalign;
`endif

  logic          hold = 1'b0;
  logic          stray = 1'b0;
  logic          rsp_valid;
  logic [IW-1:0] rsp_data;
  logic [PW-1:0] rsp_q[$];
  logic [PW-1:0] xfer_log[$];
  int total = 0;
  int bad = 0;

  assign imem_rvalid = rsp_valid | stray;
  assign imem_rdata  = rsp_data;

  always #5 clk = ~clk;

  inst_fetch_unit #(.PC_WIDTH(PW), .INST_WIDTH(IW), .RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready),
    .pc_sel(pc_sel), .br_target(br_target)
`ifdef FETCH_MISALIGN_TRAP_EN
    , .fetch_misalign(fetch_misalign)
`endif
  );

  // In-order memory: answers each transfer one cycle after grant unless held back.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_q.delete();
      xfer_log.delete();
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      if (imem_req && imem_gnt) begin
        rsp_q.push_back(imem_addr);
        xfer_log.push_back(imem_addr);
      end
      if (!hold && rsp_q.size() > 0) begin
        logic [PW-1:0] a;
        a = rsp_q.pop_front();
        rsp_valid <= 1'b1;
        rsp_data  <= a ^ 32'hDEAD_0000;
      end else begin
        rsp_valid <= 1'b0;
      end
    end
  end

  task automatic nxt();
    @(negedge clk);
  endtask

  // Leaves the DUT in its BOOT cycle with all inputs idle.
  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; imem_gnt = 1'b0; inst_ready = 1'b0; pc_sel = 1'b0;
    br_target = '0; hold = 1'b0; stray = 1'b0;
    nxt(); nxt();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b0; imem_gnt = 1'b1; inst_ready = 1'b0; pc_sel = 1'b0; hold = 1'b0; stray = 1'b0;
    #1;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %0b want 0", imem_req); end
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr: got %h want 00000000", imem_addr); end
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b want 0", inst_valid); end
    total++; if (inst !== 32'h0) begin bad++; $display("FAIL reset_inst: got %h want 00000000", inst); end
    total++; if (inst_pc !== 32'h0) begin bad++; $display("FAIL reset_pc: got %h want 00000000", inst_pc); end
    nxt();
    reset_n = 1'b1;
    #1;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL boot_req: got %0b want 0", imem_req); end
    nxt(); #1;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      bad++; $display("FAIL boot_exit: got req=%0b addr=%h want req=1 addr=00000000", imem_req, imem_addr); end
  endtask

  task automatic test_stream();
    do_reset();
    imem_gnt = 1'b1; inst_ready = 1'b1;
    nxt(); #1;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      bad++; $display("FAIL stream_c1: got req=%0b addr=%h want req=1 addr=00000000", imem_req, imem_addr); end
    nxt(); #1;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin
      bad++; $display("FAIL stream_c2: got req=%0b addr=%h want req=1 addr=00000004", imem_req, imem_addr); end
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL stream_c2_valid: got %0b want 0", inst_valid); end
    nxt(); #1;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL stream_credit: got req=%0b want 0", imem_req); end
    total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst !== 32'hDEAD_0000) begin
      bad++; $display("FAIL stream_head0: got v=%0b pc=%h inst=%h want v=1 pc=00000000 inst=dead0000", inst_valid, inst_pc, inst); end
    nxt(); #1;
    total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h4 || inst !== 32'hDEAD_0004) begin
      bad++; $display("FAIL stream_head1: got v=%0b pc=%h inst=%h want v=1 pc=00000004 inst=dead0004", inst_valid, inst_pc, inst); end
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
      bad++; $display("FAIL stream_c4: got req=%0b addr=%h want req=1 addr=00000008", imem_req, imem_addr); end
    nxt(); #1;
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL stream_c5_valid: got %0b want 0", inst_valid); end
    nxt(); #1;
    total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h8 || inst !== 32'hDEAD_0008) begin
      bad++; $display("FAIL stream_head2: got v=%0b pc=%h inst=%h want v=1 pc=00000008 inst=dead0008", inst_valid, inst_pc, inst); end
    total++; if (xfer_log.size() < 3 || xfer_log[0] !== 32'h0 || xfer_log[1] !== 32'h4 || xfer_log[2] !== 32'h8) begin
      bad++; $display("FAIL stream_order: got %0d transfers want 0,4,8 first", xfer_log.size()); end
  endtask

  task automatic test_backpressure();
    do_reset();
    imem_gnt = 1'b1; inst_ready = 1'b0;
    nxt(); nxt(); nxt(); nxt(); #1;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL bp_full_req_c4: got %0b want 0", imem_req); end
    total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin
      bad++; $display("FAIL bp_head: got v=%0b pc=%h want v=1 pc=00000000", inst_valid, inst_pc); end
    nxt(); #1;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL bp_full_req_c5: got %0b want 0", imem_req); end
    total++; if (xfer_log.size() != 2) begin bad++; $display("FAIL bp_xfer_count: got %0d want 2", xfer_log.size()); end
    inst_ready = 1'b1;
    nxt();
    inst_ready = 1'b0;
    #1;
    total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h4) begin
      bad++; $display("FAIL bp_after_pop: got v=%0b pc=%h want v=1 pc=00000004", inst_valid, inst_pc); end
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
      bad++; $display("FAIL bp_resume: got req=%0b addr=%h want req=1 addr=00000008", imem_req, imem_addr); end
    nxt(); #1;
    total++; if (xfer_log.size() != 3 || xfer_log[2] !== 32'h8) begin
      bad++; $display("FAIL bp_third_xfer: got %0d transfers want 3 ending at 00000008", xfer_log.size()); end
  endtask

  task automatic test_flush();
    do_reset();
    imem_gnt = 1'b1; inst_ready = 1'b1; hold = 1'b1;
    nxt(); nxt(); nxt();
    pc_sel = 1'b1; br_target = 32'h100;
    #1;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL flush_redir_req: got %0b want 0", imem_req); end
    nxt();
    pc_sel = 1'b0; hold = 1'b0;
    #1;
    total++; if (imem_addr !== 32'h100) begin bad++; $display("FAIL flush_addr: got %h want 00000100", imem_addr); end
    for (int c = 4; c <= 6; c++) begin
      total++; if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin
        bad++; $display("FAIL flush_c%0d: got req=%0b v=%0b want req=0 v=0", c, imem_req, inst_valid); end
      nxt(); #1;
    end
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || inst_valid !== 1'b0) begin
      bad++; $display("FAIL flush_resume: got req=%0b addr=%h v=%0b want req=1 addr=00000100 v=0", imem_req, imem_addr, inst_valid); end
    nxt(); nxt(); #1;
    total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h100 || inst !== 32'hDEAD_0100) begin
      bad++; $display("FAIL flush_first_inst: got v=%0b pc=%h inst=%h want v=1 pc=00000100 inst=dead0100", inst_valid, inst_pc, inst); end
  endtask

  task automatic test_redirect_idle();
    do_reset();
    imem_gnt = 1'b1; inst_ready = 1'b0;
    nxt(); nxt(); nxt(); nxt(); nxt();
    inst_ready = 1'b1;
    nxt();
    pc_sel = 1'b1; br_target = 32'h40;
    #1;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL idle_redir_forced: got req=%0b want 0", imem_req); end
    nxt();
    pc_sel = 1'b0; inst_ready = 1'b0;
    #1;
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL idle_fifo_cleared: got v=%0b want 0", inst_valid); end
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin
      bad++; $display("FAIL idle_no_flush: got req=%0b addr=%h want req=1 addr=00000040", imem_req, imem_addr); end
    total++; if (xfer_log.size() != 2) begin bad++; $display("FAIL idle_gnt_ignored: got %0d transfers want 2", xfer_log.size()); end
  endtask

  task automatic test_wrap();
    do_reset();
    inst_ready = 1'b1;
    nxt();
    imem_gnt = 1'b1; pc_sel = 1'b1; br_target = 32'hFFFF_FFFC;
    #1;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL wrap_redir_req: got %0b want 0", imem_req); end
    nxt();
    pc_sel = 1'b0;
    #1;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
      bad++; $display("FAIL wrap_top: got req=%0b addr=%h want req=1 addr=fffffffc", imem_req, imem_addr); end
    nxt(); #1;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      bad++; $display("FAIL wrap_zero: got req=%0b addr=%h want req=1 addr=00000000", imem_req, imem_addr); end
    nxt(); #1;
    total++; if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC || inst !== 32'h2152_FFFC) begin
      bad++; $display("FAIL wrap_inst: got v=%0b pc=%h inst=%h want v=1 pc=fffffffc inst=2152fffc", inst_valid, inst_pc, inst); end
  endtask

  task automatic test_stray_rvalid();
    do_reset();
    inst_ready = 1'b0;
    nxt();
    stray = 1'b1;
    nxt();
    stray = 1'b0; imem_gnt = 1'b1;
    #1;
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL stray_no_push: got v=%0b want 0", inst_valid); end
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      bad++; $display("FAIL stray_req: got req=%0b addr=%h want req=1 addr=00000000", imem_req, imem_addr); end
    nxt(); #1;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin
      bad++; $display("FAIL stray_credit: got req=%0b addr=%h want req=1 addr=00000004", imem_req, imem_addr); end
  endtask

  task automatic test_async_reset();
    do_reset();
    imem_gnt = 1'b1; inst_ready = 1'b0;
    nxt(); nxt(); nxt();
    #2 reset_n = 1'b0;
    #1;
    total++; if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin
      bad++; $display("FAIL async_req_addr: got req=%0b addr=%h want req=0 addr=00000000", imem_req, imem_addr); end
    total++; if (inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0) begin
      bad++; $display("FAIL async_fifo: got v=%0b inst=%h pc=%h want all 0", inst_valid, inst, inst_pc); end
  endtask

  task automatic test_misalign();
    do_reset();
    imem_gnt = 1'b1; inst_ready = 1'b1;
    nxt();
    pc_sel = 1'b1; br_target = 32'h102;
    nxt();
    pc_sel = 1'b0;
    #1;
`ifdef FETCH_MISALIGN_TRAP_EN
    for (int c = 0; c < 3; c++) begin
      total++; if (fetch_misalign !== 1'b1 || imem_req !== 1'b0) begin
        bad++; $display("FAIL trap_halt_%0d: got flag=%0b req=%0b want flag=1 req=0", c, fetch_misalign, imem_req); end
      nxt(); #1;
    end
    pc_sel = 1'b1; br_target = 32'h200;
    nxt();
    pc_sel = 1'b0;
    #1;
    total++; if (fetch_misalign !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      bad++; $display("FAIL trap_resume: got flag=%0b req=%0b addr=%h want flag=0 req=1 addr=00000200", fetch_misalign, imem_req, imem_addr); end
`else
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      bad++; $display("FAIL align_force: got req=%0b addr=%h want req=1 addr=00000100", imem_req, imem_addr); end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_redirect_idle();
    test_wrap();
    test_stray_rvalid();
    test_async_reset();
    test_misalign();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
